// File: rtl/reg_writeback_queue.sv
// Write-side front end for the register file: ALU results take the single write
// port first, LSU results wait in a small FIFO, and a scoreboard tracks pending writes.
module reg_writeback_queue #(
  parameter int N     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_rd,
  input  logic [N-1:0]             alu_data,
  input  logic                     lsu_valid,
  output logic                     lsu_ready,
  input  logic [4:0]               lsu_rd,
  input  logic [N-1:0]             lsu_data,
  input  logic                     issue_valid,
  input  logic [4:0]               issue_rd,
  output logic [31:0]              busy_mask,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     rf_write,
  output logic [4:0]               rf_WriteReg,
  output logic [N-1:0]             rf_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]    rd_mem_q   [DEPTH];
  logic [4:0]    rd_mem_d   [DEPTH];
  logic [N-1:0]  data_mem_q [DEPTH];
  logic [N-1:0]  data_mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rf_write_q, rf_write_d;
  logic [4:0]    rf_write_reg_q, rf_write_reg_d;
  logic [N-1:0]  rf_data_q, rf_data_d;
  logic [31:0]   busy_q, busy_d;
  logic          alu_take, push, pop;

  // A full FIFO never accepts, even when it pops on the same edge.
  always_comb begin
    lsu_ready  = (count_q != CW'(DEPTH));
    alu_take   = alu_valid && (alu_rd != 5'd0);
    push       = lsu_valid && lsu_ready && (lsu_rd != 5'd0);
    pop        = !alu_take && (count_q != '0);

    rd_mem_d   = rd_mem_q;
    data_mem_d = data_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (push) begin
      rd_mem_d[wr_ptr_q]   = lsu_rd;
      data_mem_d[wr_ptr_q] = lsu_data;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end

    rf_write_d     = 1'b0;
    rf_write_reg_d = rf_write_reg_q;
    rf_data_d      = rf_data_q;
    if (alu_take) begin
      rf_write_d     = 1'b1;
      rf_write_reg_d = alu_rd;
      rf_data_d      = alu_data;
    end else if (pop) begin
      rf_write_d     = 1'b1;
      rf_write_reg_d = rd_mem_q[rd_ptr_q];
      rf_data_d      = data_mem_q[rd_ptr_q];
    end

    // Clear first so that a same-edge issue to the committing register stays busy.
    busy_d = busy_q;
    if (rf_write_q) begin
      busy_d[rf_write_reg_q] = 1'b0;
    end
    if (issue_valid && (issue_rd != 5'd0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      rf_write_q     <= 1'b0;
      rf_write_reg_q <= 5'd0;
      rf_data_q      <= '0;
      busy_q         <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      rf_write_q     <= rf_write_d;
      rf_write_reg_q <= rf_write_reg_d;
      rf_data_q      <= rf_data_d;
      busy_q         <= busy_d;
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    rd_mem_q   <= rd_mem_d;
    data_mem_q <= data_mem_d;
  end

  assign busy_mask   = busy_q;
  assign fifo_count  = count_q;
  assign rf_write    = rf_write_q;
  assign rf_WriteReg = rf_write_reg_q;
  assign rf_data     = rf_data_q;

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Self-checking bench for reg_writeback_queue: directed scenarios plus a random soak,
// all compared against a queue-based reference model of the write-back rules.
module tb_reg_writeback_queue;

   localparam int N     = 32;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } entry_t;

   logic        clk;
   logic        rst;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        lsu_valid;
   logic        lsu_ready;
   logic [4:0]  lsu_rd;
   logic [31:0] lsu_data;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic [31:0] busy_mask;
   logic [2:0]  fifo_count;
   logic        rf_write;
   logic [4:0]  rf_WriteReg;
   logic [31:0] rf_data;

   entry_t      mq[$];
   logic        mWrite;
   logic [4:0]  mWriteReg;
   logic [31:0] mData;
   logic [31:0] mBusy;
   logic [31:0] mRf [32];
   logic [31:0] dutRf [32];
   int          mPops;
   int          nChecks;
   int          nFails;

   reg_writeback_queue #(.N(N), .DEPTH(DEPTH)) dut (
      .clk(clk),
      .rst(rst),
      .alu_valid(alu_valid),
      .alu_rd(alu_rd),
      .alu_data(alu_data),
      .lsu_valid(lsu_valid),
      .lsu_ready(lsu_ready),
      .lsu_rd(lsu_rd),
      .lsu_data(lsu_data),
      .issue_valid(issue_valid),
      .issue_rd(issue_rd),
      .busy_mask(busy_mask),
      .fifo_count(fifo_count),
      .rf_write(rf_write),
      .rf_WriteReg(rf_WriteReg),
      .rf_data(rf_data)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Register file as the DUT drives it, compared against the model's at the end.
   always @(posedge clk) begin
      if (rf_write === 1'b1) begin
         dutRf[rf_WriteReg] <= rf_data;
      end
   end

   // Single comparison point: counts every check and reports any disagreement.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      if (obs !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: advances by one clock edge using the currently driven inputs.
   task automatic modelStep();
      logic        accept;
      logic [31:0] nextBusy;
      entry_t      head;
      if (mWrite) mRf[mWriteReg] = mData;
      if (rst) begin
         mq.delete();
         mWrite    = 1'b0;
         mWriteReg = 5'd0;
         mData     = 32'd0;
         mBusy     = 32'd0;
         return;
      end
      accept   = lsu_valid && (mq.size() < DEPTH);
      nextBusy = mBusy;
      if (mWrite) nextBusy[mWriteReg] = 1'b0;
      if (issue_valid && issue_rd != 5'd0) nextBusy[issue_rd] = 1'b1;
      nextBusy[0] = 1'b0;
      mBusy = nextBusy;
      if (alu_valid && alu_rd != 5'd0) begin
         mWrite    = 1'b1;
         mWriteReg = alu_rd;
         mData     = alu_data;
      end else if (mq.size() > 0) begin
         head      = mq.pop_front();
         mWrite    = 1'b1;
         mWriteReg = head.rd;
         mData     = head.data;
         mPops++;
      end else begin
         mWrite = 1'b0;
      end
      if (accept && lsu_rd != 5'd0) mq.push_back('{rd: lsu_rd, data: lsu_data});
   endtask

   // Drives one cycle of inputs, advances the model and checks the post-edge outputs.
   task automatic applyStimulus(input logic r, input logic av, input logic [4:0] ard,
                                input logic [31:0] ad, input logic lv, input logic [4:0] lrd,
                                input logic [31:0] ld, input logic iv, input logic [4:0] ird);
      @(negedge clk);
      rst         = r;
      alu_valid   = av;
      alu_rd      = ard;
      alu_data    = ad;
      lsu_valid   = lv;
      lsu_rd      = lrd;
      lsu_data    = ld;
      issue_valid = iv;
      issue_rd    = ird;
      #1;
      if (!r) checkOutput("lsu_ready_pre", {31'd0, lsu_ready}, {31'd0, mq.size() != DEPTH});
      modelStep();
      @(posedge clk);
      #1;
      checkOutput("rf_write", {31'd0, rf_write}, {31'd0, mWrite});
      checkOutput("rf_WriteReg", {27'd0, rf_WriteReg}, {27'd0, mWriteReg});
      checkOutput("rf_data", rf_data, mData);
      checkOutput("busy_mask", busy_mask, mBusy);
      checkOutput("fifo_count", {29'd0, fifo_count}, mq.size());
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
   endtask

   initial begin
      int lsuIdx;
      nChecks = 0;
      nFails  = 0;
      mPops   = 0;
      mWrite  = 1'b0;
      mWriteReg = 5'd0;
      mData   = 32'd0;
      mBusy   = 32'd0;
      for (int i = 0; i < 32; i++) begin
         mRf[i]   = 32'd0;
         dutRf[i] = 32'd0;
      end
      rst = 1'b1; alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
      lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 32'd0;
      issue_valid = 1'b0; issue_rd = 5'd0;

      applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);

      // Reset: hold the port with ALU writes so three LSU entries stay queued.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b1, 5'd20, 32'h100 + i, 1'b1, 5'(21 + i), 32'h200 + i, 1'b1, 5'(24 + i));
      end
      checkOutput("fill_count", {29'd0, fifo_count}, 32'd3);
      applyStimulus(1'b1, 1'b1, 5'd20, 32'h1, 1'b1, 5'd27, 32'h2, 1'b1, 5'd28);
      checkOutput("rst_count", {29'd0, fifo_count}, 32'd0);
      checkOutput("rst_busy", busy_mask, 32'd0);
      checkOutput("rst_rf_write", {31'd0, rf_write}, 32'd0);
      checkOutput("rst_lsu_ready", {31'd0, lsu_ready}, 32'd1);
      checkOutput("rst_rf_data", rf_data, 32'd0);

      // ALU path with scoreboard set and clear.
      idleCycle();
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5);
      checkOutput("alu_busy_c1", {31'd0, busy_mask[5]}, 32'd1);
      applyStimulus(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      checkOutput("alu_busy_c2", {31'd0, busy_mask[5]}, 32'd1);
      checkOutput("alu_wreg", {27'd0, rf_WriteReg}, 32'd5);
      checkOutput("alu_data", rf_data, 32'hDEADBEEF);
      idleCycle();
      checkOutput("alu_busy_c3", {31'd0, busy_mask[5]}, 32'd0);

      // Contention: six ALU cycles while the LSU source offers x10..x15 in order.
      lsuIdx = 10;
      for (int c = 0; c < 6; c++) begin
         if (c >= 4) checkOutput("full_not_ready", {31'd0, lsu_ready}, 32'd0);
         applyStimulus(1'b0, 1'b1, 5'(c + 1), 32'h1000 + c, lsuIdx <= 15, 5'(lsuIdx),
                       32'h2000 + lsuIdx, 1'b0, 5'd0);
         if (lsuIdx <= 15 && c < 4) lsuIdx++;
      end
      for (int k = 0; k < 8; k++) begin
         logic offer;
         logic wasReady;
         offer    = (lsuIdx <= 15);
         wasReady = lsu_ready;
         applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, offer, 5'(lsuIdx), 32'h2000 + lsuIdx, 1'b0, 5'd0);
         if (k < 4) checkOutput("drain_order", {27'd0, rf_WriteReg}, 32'd10 + k);
         if (offer && wasReady) lsuIdx++;
      end
      checkOutput("all_lsu_accepted", lsuIdx, 32'd16);

      // x0 filtering on all three inputs.
      applyStimulus(1'b0, 1'b1, 5'd9, 32'h9, 1'b1, 5'd16, 32'h1616, 1'b0, 5'd0);
      applyStimulus(1'b0, 1'b1, 5'd0, 32'hBAD, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      checkOutput("x0_alu_pop_reg", {27'd0, rf_WriteReg}, 32'd16);
      checkOutput("x0_alu_pop_data", rf_data, 32'h1616);
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hBAD, 1'b1, 5'd0);
      checkOutput("x0_lsu_count", {29'd0, fifo_count}, 32'd0);
      checkOutput("x0_lsu_no_write", {31'd0, rf_write}, 32'd0);
      checkOutput("x0_issue_busy", busy_mask, 32'd0);

      // Set/clear collision on x7.
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
      applyStimulus(1'b0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
      checkOutput("collision_busy7", {31'd0, busy_mask[7]}, 32'd1);

      // Random soak.
      for (int c = 0; c < 10000; c++) begin
         applyStimulus(($urandom_range(0, 1999) == 0), ($urandom_range(0, 9) < 4),
                       5'($urandom_range(0, 31)), $urandom(), ($urandom_range(0, 1) == 1),
                       5'($urandom_range(0, 31)), $urandom(), ($urandom_range(0, 9) < 3),
                       5'($urandom_range(0, 31)));
      end
      idleCycle();
      idleCycle();
      checkOutput("pointer_wraps", {31'd0, (mPops / DEPTH) >= 100}, 32'd1);
      for (int i = 0; i < 32; i++) begin
         checkOutput($sformatf("regfile_x%0d", i), dutRf[i], mRf[i]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
      $finish;
   end

endmodule
